// File: rtl/iterative_alu.sv
// Multi-cycle execute unit: single-cycle logic/arithmetic/compare, iterative 1-bit-per-cycle shifts.
// Define ITERATIVE_ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
package iterative_alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_AND  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } aluop_e;
endpackage

module iterative_alu
  import iterative_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  aluop_e          alu_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e        state;
  logic          accept;
  logic [SW-1:0] shamt;

  function automatic logic [XLEN-1:0] exec(input aluop_e op, input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    sa = a;
    sb = b;
    case (op)
      ALU_SUB:  return a - b;
      ALU_SLT:  return {{(XLEN-1){1'b0}}, sa < sb};
      ALU_SLTU: return {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:  return a ^ b;
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
`ifdef ITERATIVE_ALU_FAST_SHIFT_EN
      ALU_SLL:  return a << b[SW-1:0];
      ALU_SRL:  return a >> b[SW-1:0];
      ALU_SRA:  return $unsigned(sa >>> b[SW-1:0]);
`endif
      default:  return a + b;  // ADD and every unlisted encoding
    endcase
  endfunction

  assign shamt    = src_b[SW-1:0];
  assign accept   = in_valid && in_ready;
  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign zero     = (result == '0);

`ifdef ITERATIVE_ALU_FAST_SHIFT_EN
  assign busy = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (accept) begin
      result    <= exec(alu_op, src_a, src_b);
      state     <= DONE;
      out_valid <= 1'b1;
    end else if (state == DONE && out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end
  end
`else
  aluop_e        op_q;
  logic [SW-1:0] cnt;

  function automatic logic is_shift(input aluop_e op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  function automatic logic [XLEN-1:0] shift1(input aluop_e op, input logic [XLEN-1:0] v);
    case (op)
      ALU_SLL: return {v[XLEN-2:0], 1'b0};
      ALU_SRL: return {1'b0, v[XLEN-1:1]};
      default: return {v[XLEN-1], v[XLEN-1:1]};
    endcase
  endfunction

  // The accept cycle performs the first shift step, so shamt s finishes after max(s,1) cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      op_q      <= ALU_ADD;
      cnt       <= '0;
    end else begin
      case (state)
        SHIFT: begin
          result <= shift1(op_q, result);
          cnt    <= cnt - SW'(1);
          if (cnt == SW'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          if (accept) begin
            op_q <= alu_op;
            if (is_shift(alu_op) && shamt > SW'(1)) begin
              result    <= shift1(alu_op, src_a);
              cnt       <= shamt - SW'(1);
              state     <= SHIFT;
              out_valid <= 1'b0;
              busy      <= 1'b1;
            end else begin
              if (!is_shift(alu_op))
                result <= exec(alu_op, src_a, src_b);
              else if (shamt == SW'(1))
                result <= shift1(alu_op, src_a);
              else
                result <= src_a;
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_iterative_alu.sv
// Bench for iterative_alu: vector table through a scoreboard plus timing corner sequences.
module tb_iterative_alu;
  import iterative_alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  aluop_e      alu_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  iterative_alu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    aluop_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    string       name;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   pop_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output actual=%h required=none", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_result"}, result, e.r);
        check({e.name, "_zero"}, {31'd0, zero}, {31'd0, e.r == 32'd0});
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Caller is positioned just after a rising edge; returns just after the accept edge.
  task automatic send(input aluop_e op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input string nm);
    int n;
    n = 0;
    alu_op = op; src_a = a; src_b = b; in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL %s_accept_timeout actual=not_ready required=ready", nm);
    end else begin
      sb.push_back('{exp, nm});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_pending", sb.size(), 0);
  endtask

  vec_t vecs[17];

  initial begin
    int lat;
    int bcnt;
    vecs[0]  = '{ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "add_wrap"};
    vecs[1]  = '{ALU_ADD,  32'd5,         32'd7,         32'd12,        "add"};
    vecs[2]  = '{ALU_SUB,  32'd3,         32'd5,         32'hFFFF_FFFE, "sub"};
    vecs[3]  = '{ALU_SLT,  32'hFFFF_FFFF, 32'd0,         32'd1,         "slt_neg"};
    vecs[4]  = '{ALU_SLT,  32'd5,         32'hFFFF_FFFD, 32'd0,         "slt_pos"};
    vecs[5]  = '{ALU_SLTU, 32'd1,         32'hFFFF_FFFF, 32'd1,         "sltu_lt"};
    vecs[6]  = '{ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         "sltu_ge"};
    vecs[7]  = '{ALU_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, "xor"};
    vecs[8]  = '{ALU_OR,   32'h0000_F000, 32'h0000_000F, 32'h0000_F00F, "or"};
    vecs[9]  = '{ALU_AND,  32'h1234_5678, 32'h0F0F_0F0F, 32'h0204_0608, "and"};
    vecs[10] = '{ALU_SLL,  32'h0000_0003, 32'h0000_0004, 32'h0000_0030, "sll4"};
    vecs[11] = '{ALU_SRL,  32'h8000_0000, 32'h0000_0021, 32'h4000_0000, "srl1"};
    vecs[12] = '{ALU_SRA,  32'h8000_0010, 32'h0000_0004, 32'hF800_0001, "sra4"};
    vecs[13] = '{ALU_SRL,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, "srl0"};
    vecs[14] = '{ALU_SLL,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, "sll31"};
    vecs[15] = '{aluop_e'(4'd12), 32'd2,  32'd3,         32'd5,         "illegal_op"};
    vecs[16] = '{ALU_SRA,  32'h7FFF_FFFF, 32'h0000_001E, 32'h0000_0001, "sra30_pos"};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = ALU_ADD; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_zero", {31'd0, zero}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Table vectors, issued back to back with the consumer always ready
    foreach (vecs[i]) send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
    drain();

    // Back-to-back non-shift ops must produce results on consecutive cycles
    pop_cyc.delete();
    send(ALU_ADD,  32'd5, 32'd7,         32'd12,        "b2b_add");
    send(ALU_SUB,  32'd3, 32'd5,         32'hFFFF_FFFE, "b2b_sub");
    send(ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd1,         "b2b_sltu");
    drain();
    check("b2b_count", pop_cyc.size(), 3);
    if (pop_cyc.size() == 3) begin
      check("b2b_gap1", pop_cyc[1] - pop_cyc[0], 1);
      check("b2b_gap2", pop_cyc[2] - pop_cyc[1], 1);
    end

    // SRA by 31: latency and busy duration
    send(ALU_SRA, 32'h8000_0000, 32'h0000_003F, 32'hFFFF_FFFF, "sra31");
    lat = 0; bcnt = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    check("sra31_latency", lat, 31);
    check("sra31_busy_cycles", bcnt, 30);
    drain();

    // Shamt zero completes in one cycle without busy
    send(ALU_SRL, 32'h1234_5678, 32'h0, 32'h1234_5678, "srl0_timed");
    @(negedge clk);
    check("srl0_latency", {31'd0, out_valid}, 32'd1);
    check("srl0_busy", {31'd0, busy}, 32'd0);
    drain();

    // Backpressure: output held, no acceptance of a waiting request
    out_ready = 1'b0;
    send(ALU_XOR, 32'hFF, 32'hFF, 32'h0, "bp_xor");
    alu_op = ALU_ADD; src_a = 32'd9; src_b = 32'd9; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_result", result, 32'd0);
      check("bp_zero", {31'd0, zero}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    check("bp_idle_after", {31'd0, out_valid}, 32'd0);

    // Reset in the 5th SHIFT cycle of SLL 1 by 20
    send(ALU_SLL, 32'd1, 32'd20, 32'h0010_0000, "rst_sll20");
    repeat (4) @(posedge clk);
    #1;
    check("midshift_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    sb.delete();
    #1;
    check("midshift_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midshift_rst_result", result, 32'd0);
    check("midshift_rst_zero", {31'd0, zero}, 32'd1);
    check("midshift_rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    send(ALU_SLL, 32'd1, 32'd20, 32'h0010_0000, "post_rst_sll20");
    send(ALU_ADD, 32'd2, 32'd2, 32'd4, "post_rst_add");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/iterative_alu.md
# iterative_alu

Multi-cycle execute unit that consumes the `aluop_e` control word produced by the ALU decoder, together with two operands, over a valid/ready handshake. Logic/arithmetic/compare ops complete in one cycle. Shifts are performed iteratively, one bit position per cycle, trading latency for area. It sits between the controller/operand-fetch side and writeback, and is the execute end of the ALU control interface in the multi-cycle variants of the core.

## Interface

Parameters:
- `XLEN`, 32, operand/result width; must be a power of two ≥ 8.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  unit can accept a request this cycle.
- `alu_op`  in  `aluop_e`  operation from the ALU decoder.
- `src_a`  in  XLEN  operand A (shift source).
- `src_b`  in  XLEN  operand B; shift amount is `src_b[$clog2(XLEN)-1:0]`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `result`  out  XLEN  operation result.
- `zero`  out  1  `result == 0`.
- `busy`  out  1  high in SHIFT state.

## Operation

- States: IDLE, SHIFT, DONE.
- `in_ready` = (state == IDLE) || (state == DONE && `out_ready`). Accept = `in_valid && in_ready`; operands and op captured in internal registers on accept.
- Accept of non-shift op (ADD, SUB, SLT, SLTU, XOR, OR, AND): result computed from captured inputs, state → DONE.
- Accept of shift op (SLL, SRL, SRA): shift register loaded with `src_a`, counter loaded with shamt. Shamt = 0 → DONE directly with `result = src_a`. Otherwise → SHIFT.
- SHIFT: each cycle shift by 1 (SLL: fill 0 at LSB; SRL: fill 0 at MSB; SRA: replicate MSB), decrement counter; on the cycle counter reaches 1 → DONE with final value.
- DONE: `out_valid` = 1; `result`/`zero` held stable until `out_ready`. On `out_ready`: if a new accept occurs in the same cycle, go to DONE or SHIFT per the new op (back-to-back); else → IDLE.
- Arithmetic: ADD/SUB modulo 2^XLEN, no carry/overflow output. SLT signed compare, SLTU unsigned; result is 1 or 0, zero-extended to XLEN.
- Any `alu_op` encoding outside the listed ops executes as ADD.
- `in_valid` while not ready: ignored, no capture; requester must hold.
- Input values only sampled on accept; changes at other times have no effect.

## Timing

- Reset (async assert, any state): state = IDLE, `out_valid` = 0, `result` = 0, `zero` = 1, `busy` = 0, `in_ready` = 1 after reset release (combinational from IDLE). In-flight operation discarded, no output produced.
- Non-shift latency: accept at edge N → `out_valid` high after edge N (visible cycle N+1).
- Shift latency: shamt `s` → `out_valid` visible `max(s,1)` cycles after the accept cycle; `busy` high for `s−1` cycles for s ≥ 2, otherwise never.
- Throughput with `out_ready` held high: one non-shift op per cycle.
- `out_valid` never deasserts without `out_ready` being sampled high.

## Configuration

- `ITERATIVE_ALU_FAST_SHIFT_EN` defined: shifts use a single-cycle barrel shifter; all ops follow non-shift timing, SHIFT state unreachable, `busy` tied 0.
- Undefined (default): iterative shifting as described above.

## Test plan

- Reset mid-shift: SLL `src_a`=1, shamt=20, assert `rst` in 5th SHIFT cycle → `out_valid`=0, `result`=0, `zero`=1 immediately; next request completes normally.
- Back-to-back non-shift with `out_ready`=1: ADD 5+7, SUB 3−5, SLTU 1 vs 0xFFFFFFFF → results 12, 0xFFFFFFFE, 1 on consecutive cycles.
- SRA `src_a`=0x80000000, `src_b`=0x0000003F (shamt 31) → `result`=0xFFFFFFFF after 31 cycles; `busy` high 30 cycles.
- Shamt zero and max: SRL 0x1234_5678 by 0 → 0x1234_5678 in 1 cycle; SLL 1 by 31 → 0x80000000.
- Backpressure: XOR 0xFF^0xFF with `out_ready`=0 for 4 cycles → `result`=0, `zero`=1 held, `in_ready`=0, new `in_valid` ignored; released on `out_ready`.
- Signed compare / illegal op: SLT 0xFFFFFFFF vs 0 → 1; undefined `alu_op` encoding with 2,3 → 5.
